// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one data-memory request per load/store and fills the MEM/WB register.
// Latency: 1 cycle for non-memory ops, 2+ cycles for memory ops (detect + REQ until ack or timeout).
// Backpressure: stall_o freezes upstream while a request is pending; MEM/WB takes bubbles meanwhile.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RTdata_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        Branch_i,
    input  logic        zero_i,
    input  logic [31:0] sum_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        stall_o,
    output logic        PCSrc_o,
    output logic [31:0] branch_target_o,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RDaddr_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    typedef enum logic {IDLE, REQ} state_t;

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd_addr;
    } wb_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    wb_t        wb_q;
    logic       held_reg_write;
    logic       held_mem_to_reg;
    logic [4:0] held_rd_addr;

    logic access;
    logic aligned;
    logic wait_last;

    assign access    = MemRead_i | MemWrite_i;
    assign aligned   = (ALUResult_i[1:0] == 2'b00);
    assign wait_last = (wait_cnt == WAIT_LAST);

    assign PCSrc_o         = Branch_i & zero_i;
    assign branch_target_o = sum_i;

    assign RegWrite_o  = wb_q.reg_write;
    assign MemtoReg_o  = wb_q.mem_to_reg;
    assign ALUResult_o = wb_q.alu_result;
    assign ReadData_o  = wb_q.read_data;
    assign RDaddr_o    = wb_q.rd_addr;

    // On the final wait cycle stall drops so upstream advances as the request is abandoned.
    always_comb begin
        stall_o = 1'b0;
        if (rst_n_i) begin
            case (state)
                IDLE:    stall_o = access & aligned;
                REQ:     stall_o = ~mem_ack_i & ~wait_last;
                default: stall_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_wdata_o     <= '0;
            wb_q            <= '0;
            held_reg_write  <= 1'b0;
            held_mem_to_reg <= 1'b0;
            held_rd_addr    <= '0;
            misalign_o      <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && aligned) begin
                        state           <= REQ;
                        wait_cnt        <= '0;
                        mem_req_o       <= 1'b1;
                        mem_we_o        <= MemWrite_i;
                        mem_addr_o      <= ALUResult_i;
                        mem_wdata_o     <= RTdata_i;
                        held_reg_write  <= RegWrite_i;
                        held_mem_to_reg <= MemtoReg_i;
                        held_rd_addr    <= RDaddr_i;
                        wb_q            <= '0;
                    end else begin
                        // Misaligned accesses pass through with register write suppressed.
                        wb_q.reg_write  <= RegWrite_i & ~access;
                        wb_q.mem_to_reg <= MemtoReg_i;
                        wb_q.alu_result <= ALUResult_i;
                        wb_q.read_data  <= '0;
                        wb_q.rd_addr    <= RDaddr_i;
                        if (access) begin
                            misalign_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        state           <= IDLE;
                        mem_req_o       <= 1'b0;
                        wb_q.reg_write  <= held_reg_write;
                        wb_q.mem_to_reg <= held_mem_to_reg;
                        wb_q.alu_result <= mem_addr_o;
                        wb_q.read_data  <= mem_we_o ? 32'd0 : mem_rdata_i;
                        wb_q.rd_addr    <= held_rd_addr;
                    end else if (wait_last) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        timeout_o <= 1'b1;
                        wb_q      <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        wb_q     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed vectors for mem_access_stage with a queue-based scoreboard sampled on the falling edge.
module tb_mem_access_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic        br;
        logic        z;
        logic [31:0] sum;
        logic        ack;
        logic [31:0] rdata;
        logic        rst_n;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
        logic        to;
        logic        pcsrc;
        logic [31:0] tgt;
    } obs_t;

    logic        clk_i;
    logic        rst_n_i;
    logic [31:0] ALUResult_i, RTdata_i, sum_i, mem_rdata_i;
    logic [4:0]  RDaddr_i;
    logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i, Branch_i, zero_i, mem_ack_i;
    logic        mem_req_o, mem_we_o, stall_o, PCSrc_o, RegWrite_o, MemtoReg_o, misalign_o, timeout_o;
    logic [31:0] mem_addr_o, mem_wdata_o, branch_target_o, ALUResult_o, ReadData_o;
    logic [4:0]  RDaddr_o;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .ALUResult_i(ALUResult_i), .RTdata_i(RTdata_i), .RDaddr_i(RDaddr_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .Branch_i(Branch_i), .zero_i(zero_i), .sum_i(sum_i),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .stall_o(stall_o), .PCSrc_o(PCSrc_o), .branch_target_o(branch_target_o),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ALUResult_o(ALUResult_o),
        .ReadData_o(ReadData_o), .RDaddr_o(RDaddr_o), .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    obs_t exp_q[$];
    int   id_q[$];
    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;
    in_t  vi;
    obs_t ve;

    task automatic apply();
        rst_n_i     = vi.rst_n;
        ALUResult_i = vi.alu;
        RTdata_i    = vi.rt;
        RDaddr_i    = vi.rd;
        MemRead_i   = vi.mr;
        MemWrite_i  = vi.mw;
        RegWrite_i  = vi.rw;
        MemtoReg_i  = vi.m2r;
        Branch_i    = vi.br;
        zero_i      = vi.z;
        sum_i       = vi.sum;
        mem_ack_i   = vi.ack;
        mem_rdata_i = vi.rdata;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        apply();
        exp_q.push_back(ve);
        id_q.push_back(ncyc);
        ncyc++;
    endtask

    task automatic idle();
        vi       = '0;
        vi.rst_n = 1'b1;
    endtask

    task automatic wb_clr();
        ve.rw    = 1'b0;
        ve.m2r   = 1'b0;
        ve.alu   = '0;
        ve.rdata = '0;
        ve.rd    = '0;
    endtask

    // Monitor: every falling edge with a pending expectation is compared.
    initial begin
        obs_t got;
        obs_t want;
        int   id;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                id   = id_q.pop_front();
                got.stall = stall_o;     got.req   = mem_req_o;   got.we  = mem_we_o;
                got.addr  = mem_addr_o;  got.wdata = mem_wdata_o;
                got.rw    = RegWrite_o;  got.m2r   = MemtoReg_o;  got.alu = ALUResult_o;
                got.rdata = ReadData_o;  got.rd    = RDaddr_o;
                got.mis   = misalign_o;  got.to    = timeout_o;
                got.pcsrc = PCSrc_o;     got.tgt   = branch_target_o;
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL cycle%0d outputs: got stall=%b req=%b we=%b addr=%h wdata=%h rw=%b m2r=%b alu=%h rdata=%h rd=%0d mis=%b to=%b pcsrc=%b tgt=%h | want stall=%b req=%b we=%b addr=%h wdata=%h rw=%b m2r=%b alu=%h rdata=%h rd=%0d mis=%b to=%b pcsrc=%b tgt=%h",
                             id, got.stall, got.req, got.we, got.addr, got.wdata, got.rw, got.m2r, got.alu,
                             got.rdata, got.rd, got.mis, got.to, got.pcsrc, got.tgt,
                             want.stall, want.req, want.we, want.addr, want.wdata, want.rw, want.m2r, want.alu,
                             want.rdata, want.rd, want.mis, want.to, want.pcsrc, want.tgt);
                end
            end
        end
    end

    initial begin
        vi = '0;
        ve = '0;
        apply();

        // Reset state
        step();

        // Non-memory op reaches MEM/WB after one edge
        idle(); vi.alu = 32'h11; vi.rd = 5'd3; vi.rw = 1'b1; step();
        idle(); ve.rw = 1'b1; ve.alu = 32'h11; ve.rd = 5'd3; step();

        // Aligned load, ack in the first REQ cycle
        idle(); vi.alu = 32'h100; vi.rd = 5'd5; vi.mr = 1'b1; vi.rw = 1'b1; vi.m2r = 1'b1;
        ve = '0; ve.stall = 1'b1; step();
        vi.ack = 1'b1; vi.rdata = 32'hDEADBEEF;
        ve.stall = 1'b0; ve.req = 1'b1; ve.addr = 32'h100; step();
        idle(); ve.req = 1'b0; ve.rw = 1'b1; ve.m2r = 1'b1; ve.alu = 32'h100;
        ve.rdata = 32'hDEADBEEF; ve.rd = 5'd5; step();

        // Store acked in the third REQ cycle, with a taken branch presented throughout
        idle(); vi.alu = 32'h204; vi.rt = 32'h12345678; vi.mw = 1'b1;
        vi.br = 1'b1; vi.z = 1'b1; vi.sum = 32'h40;
        wb_clr(); ve.stall = 1'b1; ve.pcsrc = 1'b1; ve.tgt = 32'h40; step();
        ve.req = 1'b1; ve.we = 1'b1; ve.addr = 32'h204; ve.wdata = 32'h12345678; step(); step();
        vi.ack = 1'b1; ve.stall = 1'b0; step();
        idle(); ve.req = 1'b0; ve.pcsrc = 1'b0; ve.tgt = '0; ve.alu = 32'h204; step();

        // Misaligned load: no request, write suppressed, sticky flag
        idle(); vi.alu = 32'h102; vi.mr = 1'b1; vi.rw = 1'b1; vi.m2r = 1'b1; vi.rd = 5'd7;
        wb_clr(); step();
        idle(); ve.m2r = 1'b1; ve.alu = 32'h102; ve.rd = 5'd7; ve.mis = 1'b1; step();

        // Ack arrives in the final permitted wait cycle: normal completion
        idle(); vi.alu = 32'h300; vi.mr = 1'b1; vi.rw = 1'b1; vi.m2r = 1'b1; vi.rd = 5'd9;
        wb_clr(); ve.stall = 1'b1; step();
        ve.req = 1'b1; ve.we = 1'b0; ve.addr = 32'h300; ve.wdata = '0; repeat (3) step();
        vi.ack = 1'b1; vi.rdata = 32'hCAFEF00D; ve.stall = 1'b0; step();
        idle(); ve.req = 1'b0; ve.rw = 1'b1; ve.m2r = 1'b1; ve.alu = 32'h300;
        ve.rdata = 32'hCAFEF00D; ve.rd = 5'd9; step();

        // No ack: abandoned after four REQ cycles
        idle(); vi.alu = 32'h400; vi.mr = 1'b1; vi.rw = 1'b1; vi.m2r = 1'b1; vi.rd = 5'd10;
        wb_clr(); ve.stall = 1'b1; step();
        ve.req = 1'b1; ve.addr = 32'h400; repeat (3) step();
        ve.stall = 1'b0; step();
        idle(); ve.req = 1'b0; ve.to = 1'b1; step();

        // Reset in the middle of a request; a later ack must be ignored
        idle(); vi.alu = 32'h500; vi.mr = 1'b1; vi.rw = 1'b1; vi.m2r = 1'b1; vi.rd = 5'd11;
        ve.stall = 1'b1; step();
        ve.req = 1'b1; ve.addr = 32'h500; step();
        vi.rst_n = 1'b0; ve = '0; step();
        idle(); vi.ack = 1'b1; vi.rdata = 32'h55; step();
        idle(); step();

        repeat (2) @(posedge clk_i);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of REQ-state cycles to wait for mem_ack_i (legal range 1..255).
REQ-002 The block SHALL have these ports, clock and reset first:
  clk_i  in  1  sole clock, rising edge
  rst_n_i  in  1  asynchronous, active-low reset
  ALUResult_i  in  32  address / ALU result from EX/MEM
  RTdata_i  in  32  store data from EX/MEM
  RDaddr_i  in  5  destination register from EX/MEM
  MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i  in  1 each  control bits from EX/MEM
  Branch_i, zero_i  in  1 each  branch control and ALU zero flag
  sum_i  in  32  branch target
  mem_ack_i  in  1  data-memory completion strobe
  mem_rdata_i  in  32  read data, valid when mem_ack_i=1
  mem_req_o  out  1  data-memory request
  mem_we_o  out  1  1=write, 0=read
  mem_addr_o, mem_wdata_o  out  32 each  request address and write data
  stall_o  out  1  freeze IF/ID/EX and EX/MEM this cycle
  PCSrc_o  out  1  Branch_i AND zero_i, combinational
  branch_target_o  out  32  sum_i, combinational
  RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control
  ALUResult_o, ReadData_o  out  32 each  MEM/WB data
  RDaddr_o  out  5  MEM/WB destination
  misalign_o, timeout_o  out  1 each  sticky error flags

Function
REQ-003 The block SHALL define access = MemRead_i OR MemWrite_i; if both are 1, the access SHALL be a write.
REQ-004 The FSM SHALL have two states: IDLE and REQ.
REQ-005 In IDLE with access=1 and ALUResult_i[1:0]=00, stall_o SHALL be 1 combinationally; at the next edge the state SHALL become REQ, mem_addr_o/mem_wdata_o/mem_we_o SHALL latch ALUResult_i/RTdata_i/MemWrite_i, and mem_req_o SHALL become 1.
REQ-006 In REQ, mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o SHALL hold stable, and stall_o SHALL equal NOT mem_ack_i.
REQ-007 In the REQ cycle where mem_ack_i=1, the next edge SHALL:
  - return the state to IDLE and drop mem_req_o;
  - load MEM/WB with the held instruction's control, ALUResult and RDaddr;
  - load ReadData_o with mem_rdata_i on reads, or with 0 on writes.
REQ-008 Minimum memory-op latency SHALL be 2 cycles (IDLE detect + one REQ cycle with ack); a non-memory instruction SHALL reach MEM/WB at the next edge with ReadData_o=0 (1 cycle).
REQ-009 While stall_o=1, MEM/WB SHALL load a bubble at each edge: RegWrite_o=0, MemtoReg_o=0, other fields 0.
REQ-010 In IDLE with access=1 and ALUResult_i[1:0]!=00, no request SHALL issue and stall_o SHALL stay 0; MEM/WB SHALL load the instruction with RegWrite_o forced 0, and misalign_o SHALL set.
REQ-011 An 8-bit wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-012 When the counter equals TIMEOUT-1 and mem_ack_i=0:
  - that cycle, stall_o SHALL be 0;
  - at the next edge, the request SHALL be abandoned, mem_req_o SHALL drop, the state SHALL return to IDLE, MEM/WB SHALL load a bubble, and timeout_o SHALL set.
REQ-013 If mem_ack_i=1 in the timeout cycle, ack SHALL win: normal completion, no timeout flag.
REQ-014 misalign_o and timeout_o SHALL be sticky, cleared only by reset.
REQ-015 PCSrc_o and branch_target_o SHALL depend only on current inputs and be unaffected by stall.

Reset
REQ-016 rst_n_i=0 SHALL immediately force state IDLE and drive all registered outputs to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, RegWrite_o, MemtoReg_o, ALUResult_o, ReadData_o, RDaddr_o, misalign_o, timeout_o, and the counter.
REQ-017 Reset asserted during REQ SHALL drop mem_req_o asynchronously; the abandoned access SHALL NOT write MEM/WB after reset release.
REQ-018 After rst_n_i rises, the first rising edge SHALL operate normally.

Verification
REQ-019 Load, addr 0x100, RDaddr=5, ack on first REQ cycle with rdata 0xDEADBEEF:
  - stall_o=1 for 1 cycle;
  - mem_req_o=1 for 1 cycle;
  - next edge: ReadData_o=0xDEADBEEF, RDaddr_o=5, RegWrite_o=1.
REQ-020 Store, addr 0x204, data 0x12345678, ack after 3 REQ cycles:
  - mem_we_o=1 with addr/data stable for 3 cycles;
  - stall_o=1 for 3 cycles;
  - 3 bubbles with RegWrite_o=0 load MEM/WB.
REQ-021 Load, addr 0x102 -> mem_req_o never asserts, stall_o=0, RegWrite_o=0 next edge, misalign_o=1 and stays 1.
REQ-022 TIMEOUT=4, load, no ack -> mem_req_o high 4 cycles, stall_o low in 4th, timeout_o=1 after; with ack in 4th cycle instead -> normal completion, timeout_o=0.
REQ-023 rst_n_i pulsed low mid-REQ -> mem_req_o=0 within same cycle, all outputs 0, later ack ignored.
REQ-024 Branch_i=1, zero_i=1, sum_i=0x40 during a stall -> PCSrc_o=1, branch_target_o=0x40 every cycle.
